pitch_track_ctrl: RTL and testbench

Sequences one frequency estimation per FFT frame. It watches the FFT output bin stream, finds the peak-magnitude bin in the allowed band, and hands that bin's index and phase to `freq_estimator` with a one-cycle start pulse. It then waits for the estimator's `done` and publishes the resulting frequency to the pitch-correction logic downstream. It sits between the FFT core and `freq_estimator`, and owns the estimator exclusively.

---
 rtl/autotune_pkg.sv | 18 +
 rtl/peak_tracker.sv | 72 +++++++
 rtl/pitch_track_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pitch_track_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/autotune_pkg.sv
// Shared widths and FSM state type for the autotune datapath.
// Consumed by pitch_track_ctrl and its peak tracker.
package autotune_pkg;

   localparam int unsigned INDEX_W = 10;
   localparam int unsigned MAG_W   = 16;
   localparam int unsigned PHASE_W = 32;
   localparam int unsigned FREQ_W  = 32;

   typedef enum logic [2:0] {
      SYNC,
      SCAN,
      LAUNCH,
      WAIT,
      PUBLISH
   } ptc_state_t;

endpackage

// File: rtl/peak_tracker.sv
// Tracks the strongest in-band bin of the current frame.
// The peak_* outputs already include the bin on the inputs this cycle.
module peak_tracker #(
   parameter int unsigned INDEX_W   = 10,
   parameter int unsigned MAG_W     = 16,
   parameter int unsigned PHASE_W   = 32,
   parameter int unsigned MIN_INDEX = 2,
   parameter int unsigned MAX_INDEX = 511
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               en,
   input  logic               clear,
   input  logic               bin_valid,
   input  logic [INDEX_W-1:0] bin_index,
   input  logic [MAG_W-1:0]   bin_mag,
   input  logic [PHASE_W-1:0] bin_phase,
   output logic               found,
   output logic [INDEX_W-1:0] peak_index,
   output logic [PHASE_W-1:0] peak_phase
);

   localparam logic [INDEX_W-1:0] LoIdx = INDEX_W'(MIN_INDEX);
   localparam logic [INDEX_W-1:0] HiIdx = INDEX_W'(MAX_INDEX);

   logic [MAG_W-1:0]   best_mag_q, best_mag_d;
   logic [INDEX_W-1:0] best_index_q, best_index_d;
   logic [PHASE_W-1:0] best_phase_q, best_phase_d;
   logic               found_q, found_d;
   logic               in_band;
   logic               take;

   always_comb begin
      in_band      = (bin_index >= LoIdx) && (bin_index <= HiIdx);
      // Strict compare keeps the earlier bin on a tie; best_mag >= 0 so a take implies mag > 0.
      take         = en && bin_valid && in_band && (bin_mag > best_mag_q);
      best_mag_d   = best_mag_q;
      best_index_d = best_index_q;
      best_phase_d = best_phase_q;
      found_d      = found_q;
      if (take) begin
         best_mag_d   = bin_mag;
         best_index_d = bin_index;
         best_phase_d = bin_phase;
         found_d      = 1'b1;
      end
      found      = found_d;
      peak_index = best_index_d;
      peak_phase = best_phase_d;
      if (clear) begin
         best_mag_d   = '0;
         best_index_d = '0;
         best_phase_d = '0;
         found_d      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         best_mag_q   <= '0;
         best_index_q <= '0;
         best_phase_q <= '0;
         found_q      <= 1'b0;
      end else begin
         best_mag_q   <= best_mag_d;
         best_index_q <= best_index_d;
         best_phase_q <= best_phase_d;
         found_q      <= found_d;
      end
   end

endmodule

// File: rtl/pitch_track_ctrl.sv
// Per-frame sequencer: finds the FFT peak bin, runs freq_estimator on it
// and publishes the resulting frequency downstream.
module pitch_track_ctrl #(
   parameter int unsigned INDEX_W   = autotune_pkg::INDEX_W,
   parameter int unsigned MAG_W     = autotune_pkg::MAG_W,
   parameter int unsigned PHASE_W   = autotune_pkg::PHASE_W,
   parameter int unsigned FREQ_W    = autotune_pkg::FREQ_W,
   parameter int unsigned MIN_INDEX = 2,
   parameter int unsigned MAX_INDEX = 511,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               bin_valid,
   input  logic [INDEX_W-1:0] bin_index,
   input  logic [MAG_W-1:0]   bin_mag,
   input  logic [PHASE_W-1:0] bin_phase,
   input  logic               bin_last,
   output logic               est_start,
   output logic [INDEX_W-1:0] est_max_index,
   output logic [PHASE_W-1:0] est_max_phase,
   input  logic               est_done,
   input  logic [FREQ_W-1:0]  est_frequency,
   output logic [FREQ_W-1:0]  freq_out,
   output logic               freq_valid,
   output logic               busy,
   output logic [7:0]         overrun_count,
   output logic               timeout_err
);

   import autotune_pkg::*;

   localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   ptc_state_t         state_q, state_d, ret_state;
   logic               mid_frame_q, mid_frame_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [7:0]         overrun_q, overrun_d;
   logic               est_start_q, est_start_d;
   logic [INDEX_W-1:0] idx_q, idx_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [FREQ_W-1:0]  freq_q, freq_d;
   logic               freq_valid_q, freq_valid_d;
   logic               busy_q, busy_d;
   logic               timeout_q, timeout_d;

   logic               frame_end;
   logic               trk_en, trk_clear, trk_found;
   logic [INDEX_W-1:0] trk_index;
   logic [PHASE_W-1:0] trk_phase;

   peak_tracker #(
      .INDEX_W   (INDEX_W),
      .MAG_W     (MAG_W),
      .PHASE_W   (PHASE_W),
      .MIN_INDEX (MIN_INDEX),
      .MAX_INDEX (MAX_INDEX)
   ) u_peak_tracker (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (trk_en),
      .clear      (trk_clear),
      .bin_valid  (bin_valid),
      .bin_index  (bin_index),
      .bin_mag    (bin_mag),
      .bin_phase  (bin_phase),
      .found      (trk_found),
      .peak_index (trk_index),
      .peak_phase (trk_phase)
   );

   always_comb begin
      frame_end    = bin_valid && bin_last;
      state_d      = state_q;
      mid_frame_d  = mid_frame_q;
      cnt_d        = cnt_q;
      overrun_d    = overrun_q;
      est_start_d  = 1'b0;
      idx_d        = idx_q;
      phase_d      = phase_q;
      freq_d       = freq_q;
      freq_valid_d = 1'b0;
      busy_d       = busy_q;
      timeout_d    = timeout_q;
      trk_en       = (state_q == SCAN);
      trk_clear    = 1'b0;

      if (bin_valid) begin
         mid_frame_d = !bin_last;
      end
      if (frame_end && (state_q != SCAN) && (overrun_q != 8'hFF)) begin
         overrun_d = overrun_q + 8'd1;
      end
      // Resume on a frame boundary: wait out a partially seen frame in SYNC.
      ret_state = mid_frame_d ? SYNC : SCAN;

      unique case (state_q)
         SYNC: begin
            if (frame_end) begin
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (frame_end) begin
               if (trk_found) begin
                  state_d     = LAUNCH;
                  est_start_d = 1'b1;
                  busy_d      = 1'b1;
                  idx_d       = trk_index;
                  phase_d     = trk_phase;
               end else begin
                  trk_clear = 1'b1;
               end
            end
         end
         LAUNCH: begin
            trk_clear = 1'b1;
            cnt_d     = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            if (est_done) begin
               freq_d       = est_frequency;
               freq_valid_d = 1'b1;
               state_d      = PUBLISH;
            end else if (cnt_q == CntLast) begin
               timeout_d = 1'b1;
               busy_d    = 1'b0;
               state_d   = ret_state;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PUBLISH: begin
            busy_d  = 1'b0;
            state_d = ret_state;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = SCAN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= SCAN;
         mid_frame_q  <= 1'b0;
         cnt_q        <= '0;
         overrun_q    <= '0;
         est_start_q  <= 1'b0;
         idx_q        <= '0;
         phase_q      <= '0;
         freq_q       <= '0;
         freq_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         mid_frame_q  <= mid_frame_d;
         cnt_q        <= cnt_d;
         overrun_q    <= overrun_d;
         est_start_q  <= est_start_d;
         idx_q        <= idx_d;
         phase_q      <= phase_d;
         freq_q       <= freq_d;
         freq_valid_q <= freq_valid_d;
         busy_q       <= busy_d;
         timeout_q    <= timeout_d;
      end
   end

   assign est_start     = est_start_q;
   assign est_max_index = idx_q;
   assign est_max_phase = phase_q;
   assign freq_out      = freq_q;
   assign freq_valid    = freq_valid_q;
   assign busy          = busy_q;
   assign overrun_count = overrun_q;
   assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_pitch_track_ctrl.sv
// Directed bench for pitch_track_ctrl with a small latency-programmable
// freq_estimator model.
module tb_pitch_track_ctrl;

   localparam int unsigned TIMEOUT = 2000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        bin_valid;
   logic [9:0]  bin_index;
   logic [15:0] bin_mag;
   logic [31:0] bin_phase;
   logic        bin_last;
   logic        est_start;
   logic [9:0]  est_max_index;
   logic [31:0] est_max_phase;
   logic        est_done;
   logic [31:0] est_frequency;
   logic [31:0] freq_out;
   logic        freq_valid;
   logic        busy;
   logic [7:0]  overrun_count;
   logic        timeout_err;

   always #5 clk = ~clk;

   pitch_track_ctrl #(
      .INDEX_W   (10),
      .MAG_W     (16),
      .PHASE_W   (32),
      .FREQ_W    (32),
      .MIN_INDEX (2),
      .MAX_INDEX (511),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .bin_valid     (bin_valid),
      .bin_index     (bin_index),
      .bin_mag       (bin_mag),
      .bin_phase     (bin_phase),
      .bin_last      (bin_last),
      .est_start     (est_start),
      .est_max_index (est_max_index),
      .est_max_phase (est_max_phase),
      .est_done      (est_done),
      .est_frequency (est_frequency),
      .freq_out      (freq_out),
      .freq_valid    (freq_valid),
      .busy          (busy),
      .overrun_count (overrun_count),
      .timeout_err   (timeout_err)
   );

   typedef struct {
      int          i0; logic [15:0] m0; logic [31:0] p0;
      int          i1; logic [15:0] m1; logic [31:0] p1;
      int          i2; logic [15:0] m2; logic [31:0] p2;
      int          lat;
      logic [31:0] freq;
      logic        launch;
      logic [9:0]  exp_idx;
      logic [31:0] exp_phase;
   } vec_t;

   vec_t        vecs[6];
   logic [15:0] mag_a[512];
   logic [31:0] ph_a[512];

   int checks = 0;
   int failures = 0;

   // Estimator model and pulse monitor
   logic        model_en = 1'b0;
   int          model_lat = 1;
   logic [31:0] model_freq = '0;
   logic        model_done = 1'b0;
   logic        man_done = 1'b0;
   bit          pend = 0;
   int          cnt = 0;
   int          fv_cnt = 0;

   assign est_done      = model_done | man_done;
   assign est_frequency = model_freq;

   initial begin
      forever begin
         @(negedge clk);
         model_done = 1'b0;
         if (pend) begin
            cnt--;
            if (cnt <= 0) begin
               model_done = 1'b1;
               pend = 0;
            end
         end
         if (est_start && model_en) begin
            pend = 1;
            cnt  = model_lat;
         end
         if (freq_valid) fv_cnt++;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fill(input vec_t v);
      for (int i = 0; i < 512; i++) begin
         mag_a[i] = '0;
         ph_a[i]  = 32'hA500_0000 | 32'(i);
      end
      mag_a[v.i0] = v.m0; ph_a[v.i0] = v.p0;
      mag_a[v.i1] = v.m1; ph_a[v.i1] = v.p1;
      mag_a[v.i2] = v.m2; ph_a[v.i2] = v.p2;
   endtask

   // Returns at the negedge one cycle after bin_last was accepted.
   task automatic send_frame();
      for (int i = 0; i < 512; i++) begin
         @(negedge clk);
         bin_valid = 1'b1;
         bin_index = 10'(i);
         bin_mag   = mag_a[i];
         bin_phase = ph_a[i];
         bin_last  = (i == 511);
      end
      @(negedge clk);
      bin_valid = 1'b0;
      bin_last  = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int  fv0;
      int  k;
      bit  quiet;
      fill(v);
      model_en   = v.launch;
      model_lat  = v.lat;
      model_freq = v.freq;
      fv0 = fv_cnt;
      send_frame();
      check({tag, "_est_start"}, est_start, v.launch);
      if (v.launch) begin
         check({tag, "_index"}, est_max_index, v.exp_idx);
         check({tag, "_phase"}, est_max_phase, v.exp_phase);
         check({tag, "_busy_launch"}, busy, 1);
         k = 0;
         for (int c = 1; c <= v.lat + 20 && k == 0; c++) begin
            @(negedge clk);
            if (freq_valid) k = c;
         end
         check({tag, "_publish_cycle"}, k, v.lat + 1);
         check({tag, "_freq_out"}, freq_out, v.freq);
         @(negedge clk);
         check({tag, "_busy_after"}, busy, 0);
         check({tag, "_fv_pulses"}, fv_cnt - fv0, 1);
      end else begin
         quiet = 1;
         repeat (30) begin
            @(negedge clk);
            if (busy || est_start || freq_valid) quiet = 0;
         end
         check({tag, "_quiet"}, quiet, 1);
         check({tag, "_fv_pulses"}, fv_cnt - fv0, 0);
      end
   endtask

   initial begin
      vec_t        t;
      int          k;
      int          fv0;
      bit          quiet;
      logic [31:0] prev_freq;

      vecs[0] = '{150, 16'h4000, 32'h0010_0000, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0,
                  20, 32'h1B80_0000, 1'b1, 10'd150, 32'h0010_0000};
      vecs[1] = '{1, 16'h7FFF, 32'h11, 3, 16'h1000, 32'h33, 200, 16'h1000, 32'h44,
                  5, 32'h1234_5678, 1'b1, 10'd3, 32'h33};
      vecs[2] = '{1, 16'h7FFF, 32'h11, 0, 16'hFFFF, 32'h0, 0, 16'hFFFF, 32'h0,
                  5, 32'h0, 1'b0, 10'd0, 32'h0};
      vecs[3] = '{2, 16'h0100, 32'h22, 511, 16'h0101, 32'h511, 0, 16'h0, 32'h0,
                  1, 32'hCAFE_F00D, 1'b1, 10'd511, 32'h511};
      vecs[4] = '{2, 16'h0200, 32'h77, 511, 16'h0200, 32'h78, 0, 16'h0, 32'h0,
                  3, 32'h0F0F_0F0F, 1'b1, 10'd2, 32'h77};
      vecs[5] = '{77, 16'h0300, 32'h7777, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0,
                  7, 32'h0777_0000, 1'b1, 10'd77, 32'h7777};

      reset_n   = 1'b0;
      bin_valid = 1'b0;
      bin_index = '0;
      bin_mag   = '0;
      bin_phase = '0;
      bin_last  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_est_start", est_start, 0);
      check("rst_index", est_max_index, 0);
      check("rst_phase", est_max_phase, 0);
      check("rst_freq_out", freq_out, 0);
      check("rst_freq_valid", freq_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun_count, 0);
      check("rst_timeout", timeout_err, 0);
      reset_n = 1'b1;

      for (int v = 0; v < 5; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

      // Estimator never answers
      prev_freq = freq_out;
      t = '{300, 16'h0500, 32'h300, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0,
            1, 32'h0, 1'b0, 10'd0, 32'h0};
      fill(t);
      model_en = 1'b0;
      fv0 = fv_cnt;
      send_frame();
      check("to_est_start", est_start, 1);
      check("to_index", est_max_index, 300);
      check("to_err_early", timeout_err, 0);
      k = 0;
      for (int c = 1; c <= TIMEOUT + 20 && k == 0; c++) begin
         @(negedge clk);
         if (timeout_err) k = c;
      end
      check("to_err_cycle", k, TIMEOUT + 1);
      check("to_busy", busy, 0);
      check("to_freq_kept", freq_out, prev_freq);
      check("to_no_publish", fv_cnt - fv0, 0);
      run_vec(vecs[0], "after_to");

      // Two frames stream while the estimator is slow
      t = '{150, 16'h2000, 32'h150, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0,
            1000, 32'h0BAD_BEEF, 1'b1, 10'd150, 32'h150};
      check("ov_before", overrun_count, 0);
      fill(t);
      model_en   = 1'b1;
      model_lat  = 1000;
      model_freq = 32'h0BAD_BEEF;
      fv0 = fv_cnt;
      send_frame();
      check("ov_est_start", est_start, 1);
      t.i0 = 10;
      t.m0 = 16'h6000;
      fill(t);
      send_frame();
      t.i0 = 500;
      fill(t);
      send_frame();
      check("ov_count", overrun_count, 2);
      check("ov_sync_no_launch", est_start, 0);
      check("ov_busy", busy, 0);
      check("ov_freq_out", freq_out, 32'h0BAD_BEEF);
      check("ov_fv_pulses", fv_cnt - fv0, 1);
      run_vec(vecs[5], "after_ov");

      // Reset while waiting; a late done must be dropped
      t = '{40, 16'h0100, 32'h40, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0,
            1, 32'h0, 1'b0, 10'd0, 32'h0};
      fill(t);
      model_en = 1'b0;
      send_frame();
      check("rw_est_start", est_start, 1);
      repeat (10) @(negedge clk);
      check("rw_busy_wait", busy, 1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n    = 1'b1;
      man_done   = 1'b1;
      model_freq = 32'hFFFF_0000;
      fv0 = fv_cnt;
      @(negedge clk);
      man_done = 1'b0;
      quiet = 1;
      repeat (5) begin
         @(negedge clk);
         if (freq_valid || busy || est_start) quiet = 0;
      end
      check("rw_quiet", quiet, 1);
      check("rw_fv_pulses", fv_cnt - fv0, 0);
      check("rw_index", est_max_index, 0);
      check("rw_phase", est_max_phase, 0);
      check("rw_freq_out", freq_out, 0);
      check("rw_overrun", overrun_count, 0);
      check("rw_timeout", timeout_err, 0);
      run_vec(vecs[1], "after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
